wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 17 +
 rtl/wb_result_fifo.sv | 65 ++++++
 rtl/wb_port_arbiter.sv | 109 ++++++++++
 tb/tb_wb_port_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter: register-address width,
// result-FIFO entry layout and the starvation FSM states.
package wb_port_arbiter_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FORCE
  } arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result queue: circular buffer with occupancy count and a
// per-entry destination-register match against two decode sources.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_entry_t                wdata_i,
  input  logic [REG_AW-1:0]        rs1_i,
  input  logic [REG_AW-1:0]        rs2_i,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DEPTH-1:0]         match_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0]  vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rptr_q] = 1'b0;
    if (push_i) vld_d[wptr_q] = 1'b1;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // Payload is not reset; vld_q qualifies every use of it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match_o[i] = vld_q[i] &&
                        (((rs1_i != '0) && (mem_q[i].rd == rs1_i)) ||
                         ((rs2_i != '0) && (mem_q[i].rd == rs2_i)));
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline (priority) and a
// queued long-latency unit; a starved queue head forces a one-cycle stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wen,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              raw_hazard,
  output logic              stall_pipe,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int SCW = $clog2(STARVE_LIMIT+1);
  localparam logic [SCW-1:0] LIM1 = SCW'(STARVE_LIMIT-1);

  arb_state_e      state_q, state_d;
  logic [SCW-1:0]  starve_q, starve_d;
  wb_entry_t       head, lu_entry;
  logic            full, empty, pipe_act, pop, push, occ_nz_d;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] match;

  assign stall_pipe = (state_q == ST_FORCE);
  assign pipe_act   = pipe_wen && (pipe_waddr != '0) && !stall_pipe;
  assign pop        = !pipe_act && !empty;
  // Gating with rst_n keeps the handshake closed while the queue is held clear.
  assign lu_ready   = rst_n && !full;
  assign push       = lu_valid && lu_ready && (lu_rd != '0);
  assign lu_entry   = '{rd: lu_rd, data: lu_data};
  assign occ_nz_d   = ((count + CW'(push) - CW'(pop)) != '0);

  assign rf_wen     = rst_n && (pipe_act || pop);
  assign rf_waddr   = pipe_act ? pipe_waddr : (pop ? head.rd   : '0);
  assign rf_wdata   = pipe_act ? pipe_wdata : (pop ? head.data : '0);
  assign raw_hazard = |match;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (lu_entry),
    .rs1_i   (id_rs1),
    .rs2_i   (id_rs2),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .match_o (match)
  );

  // starve_q holds how many cycles the current head has already waited.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !pop) begin
          starve_d = SCW'(1);
          state_d  = (starve_d >= LIM1) ? ST_FORCE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pop) begin
          starve_d = '0;
          state_d  = occ_nz_d ? ST_WAIT : ST_IDLE;
        end else if (empty) begin
          starve_d = '0;
          state_d  = ST_IDLE;
        end else begin
          starve_d = starve_q + 1'b1;
          if (starve_d >= LIM1) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        starve_d = '0;
        state_d  = occ_nz_d ? ST_WAIT : ST_IDLE;
      end
      default: begin
        starve_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: a queue-level reference model predicts each cycle's
// outputs and write stream; a negedge monitor compares against the DUT.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pipe_wen = 1'b0, lu_valid = 1'b0;
  logic [4:0]  pipe_waddr = '0, lu_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic [31:0] pipe_wdata = '0, lu_data = '0;
  logic        lu_ready, raw_hazard, stall_pipe, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .raw_hazard(raw_hazard), .stall_pipe(stall_pipe),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wen; logic rdy; logic raw; logic stall; } exp_t;
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  wr_t  mq[$];     // model of queued long-latency results
  int   mwait;     // cycles the model head has waited so far
  bit   lu_acc;
  int   pass_cnt = 0, chk_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    chk_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
  endtask

  // Predict this cycle from the model, queue the expectation, advance a clock.
  task automatic tick();
    exp_t e;
    bit   pact, pop;
    e = '0;
    lu_acc = 1'b0;
    if (!rst_n) begin
      mq.delete();
      mwait = 0;
    end else begin
      e.stall = (mq.size() > 0) && (mwait >= LIMIT-1);
      pact    = pipe_wen && (pipe_waddr != 0) && !e.stall;
      pop     = !pact && (mq.size() > 0);
      e.rdy   = (mq.size() < DEPTH);
      foreach (mq[i])
        if ((id_rs1 != 0 && mq[i].a == id_rs1) || (id_rs2 != 0 && mq[i].a == id_rs2)) e.raw = 1'b1;
      e.wen = pact || pop;
      if (pact)     wr_q.push_back('{pipe_waddr, pipe_wdata});
      else if (pop) wr_q.push_back(mq[0]);
      lu_acc = lu_valid && e.rdy;
      if (pop) begin
        void'(mq.pop_front());
        mwait = 0;
      end else if (mq.size() > 0) mwait++;
      if (lu_acc && lu_rd != 0) mq.push_back('{lu_rd, lu_data});
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      wr_t  w;
      e = exp_q.pop_front();
      check("ctrl{wen,rdy,raw,stall}", 64'({rf_wen, lu_ready, raw_hazard, stall_pipe}), 64'(e));
      if (rf_wen) begin
        if (wr_q.size() == 0) check("unexpected_write", 64'({rf_waddr, rf_wdata}), 64'(0));
        else begin
          w = wr_q.pop_front();
          check("write{addr,data}", 64'({rf_waddr, rf_wdata}), 64'(w));
        end
      end
    end
  end

  task automatic set_pipe(input logic w, input logic [4:0] a, input logic [31:0] d);
    pipe_wen = w; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] r, input logic [31:0] d);
    lu_valid = v; lu_rd = r; lu_data = d;
  endtask

  initial begin
    mwait = 0;
    @(posedge clk); #1;
    // Reset held with a pipeline request present
    set_pipe(1, 5'd4, 32'h44);
    #1;
    check("reset_rf_wen", 64'(rf_wen), 64'(0));
    check("reset_lu_ready", 64'(lu_ready), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    set_pipe(0, 0, 0);

    // Idle pipe, one result rd=5
    set_lu(1, 5'd5, 32'h1234);
    tick();
    if (lu_acc) lu_valid = 0;
    id_rs1 = 5'd5;
    #1;
    check("lu_wr_wen", 64'(rf_wen), 64'(1));
    check("lu_wr_addr", 64'(rf_waddr), 64'(5));
    check("lu_wr_data", 64'(rf_wdata), 64'(32'h1234));
    tick();
    #1;
    check("lu_wr_drained_raw", 64'(raw_hazard), 64'(0));
    id_rs1 = 0;

    // Busy pipe rd=3, one queued result starves until forced
    set_pipe(1, 5'd3, 32'h33);
    set_lu(1, 5'd9, 32'hABCD);
    tick();
    if (lu_acc) lu_valid = 0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      if (k == 8) begin
        check("starve_stall", 64'(stall_pipe), 64'(1));
        check("starve_head_addr", 64'(rf_waddr), 64'(9));
        check("starve_head_data", 64'(rf_wdata), 64'(32'hABCD));
      end else if (k == 9) begin
        check("starve_release", 64'(stall_pipe), 64'(0));
        check("starve_pipe_replay", 64'(rf_waddr), 64'(3));
      end
      tick();
    end

    // Fill with pipe busy; third result held until space frees
    for (int k = 0; k < 12; k++) begin
      if (k < 3) set_lu(1, 5'(10 + k), 32'(32'h100 + k));
      #1;
      if (k == 2) check("full_lu_ready", 64'(lu_ready), 64'(0));
      if (k == 9) check("full_lu_ready_after_pop", 64'(lu_ready), 64'(1));
      tick();
      if (lu_acc) lu_valid = 0;
    end
    set_pipe(0, 0, 0);
    repeat (4) tick();

    // rd=0 from both sources
    set_pipe(1, 5'd0, 32'h55);
    set_lu(1, 5'd0, 32'h66);
    #1;
    check("zero_rd_wen", 64'(rf_wen), 64'(0));
    tick();
    if (lu_acc) lu_valid = 0;
    set_pipe(0, 0, 0);
    #1;
    check("zero_rd_not_queued", 64'(rf_wen), 64'(0));
    tick();

    // RAW hazard on queued rd=7
    set_pipe(1, 5'd3, 32'h77);
    set_lu(1, 5'd7, 32'h700);
    tick();
    if (lu_acc) lu_valid = 0;
    id_rs1 = 5'd4; id_rs2 = 5'd7;
    #1;
    check("raw_rs2_hit", 64'(raw_hazard), 64'(1));
    tick();
    set_pipe(0, 0, 0);
    tick();
    #1;
    check("raw_after_drain", 64'(raw_hazard), 64'(0));
    id_rs1 = 0; id_rs2 = 0;
    set_lu(1, 5'd0, 32'h1);
    tick();
    if (lu_acc) lu_valid = 0;
    #1;
    check("raw_rs0_never", 64'(raw_hazard), 64'(0));
    tick();

    // Reset with two queued entries while waiting
    set_pipe(1, 5'd3, 32'h88);
    set_lu(1, 5'd20, 32'h2020);
    tick();
    if (lu_acc) lu_valid = 0;
    set_lu(1, 5'd21, 32'h2121);
    tick();
    if (lu_acc) lu_valid = 0;
    tick(); tick();
    id_rs1 = 5'd20;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({rf_wen, lu_ready, stall_pipe, raw_hazard}), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    set_pipe(0, 0, 0);
    #1;
    check("post_rst_ready", 64'(lu_ready), 64'(1));
    repeat (3) tick();
    id_rs1 = 0;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      set_pipe($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      if (!lu_valid && $urandom_range(0, 2) == 0) set_lu(1, 5'($urandom_range(0, 15)), $urandom);
      id_rs1 = 5'($urandom_range(0, 15));
      id_rs2 = 5'($urandom_range(0, 15));
      rst_n = (c != 250);
      tick();
      if (lu_acc || !rst_n) lu_valid = 0;
    end
    rst_n = 1'b1;
    set_pipe(0, 0, 0);
    lu_valid = 0;
    repeat (6) tick();
    @(negedge clk); #1;
    check("writes_all_seen", 64'(wr_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
